// File: rtl/move_repeat_if.sv
// Key-to-move handshake bundle between the PS/2 key decoder side and the player stage.
interface move_repeat_if;
    logic [3:0] key_held;
    logic       ready;
    logic [3:0] move;
    logic       active;
    logic [1:0] dir;

    modport master (output key_held, ready, input  move, active, dir);
    modport slave  (input  key_held, ready, output move, active, dir);
endinterface

// File: rtl/move_repeat.sv
// Turns held direction keys into one-hot move pulses: one on press, then auto-repeat
// after DELAY_CYCLES and every REPEAT_CYCLES, gated by the player's ready handshake.
module move_repeat #(
    parameter int DELAY_CYCLES  = 12500000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 24
) (
    input  logic         clk,
    input  logic         rstn,
    move_repeat_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FIRST  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    logic [3:0]       ks_meta, ks;
    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       dir, dir_n;
    logic             pending, pending_n;
    logic [3:0]       move_q, move_n;
    logic             emit, rel, want, fire;

    function automatic logic [1:0] top_key(input logic [3:0] k);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (k[i]) idx = 2'(i);
        return idx;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ks_meta <= '0;
            ks      <= '0;
        end else begin
            ks_meta <= bus.key_held;
            ks      <= ks_meta;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dir_n   = dir;
        emit    = 1'b0;
        rel     = 1'b0;
        case (state)
            IDLE: begin
                if (|ks) begin
                    state_n = FIRST;
                    cnt_n   = '0;
                    dir_n   = top_key(ks);
                    emit    = 1'b1;
                end
            end
            FIRST: begin
                if (cnt == DELAY_TC) begin
                    emit    = 1'b1;
                    cnt_n   = '0;
                    state_n = REPEAT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (cnt == REPEAT_TC) begin
                    emit  = 1'b1;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                dir_n   = 2'd0;
            end
        endcase
        // Release beats a coincident terminal count: the move is dropped, not delivered late.
        if (state != IDLE && !ks[dir]) begin
            rel     = 1'b1;
            emit    = 1'b0;
            state_n = IDLE;
            cnt_n   = '0;
            dir_n   = 2'd0;
        end
    end

    // One outstanding move at most; a pulse is held back a cycle if the last one is still high.
    always_comb begin
        want      = emit | pending;
        fire      = want & bus.ready & ~(|move_q) & ~rel;
        pending_n = ~rel & want & ~fire;
        move_n    = fire ? (4'b0001 << dir_n) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            dir     <= 2'd0;
            pending <= 1'b0;
            move_q  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            dir     <= dir_n;
            pending <= pending_n;
            move_q  <= move_n;
        end
    end

    assign bus.move   = move_q;
    assign bus.active = (state != IDLE);
    assign bus.dir    = dir;
endmodule

// File: doc/move_repeat.md
Name: move_repeat

Overview:
- Converts held direction keys from the PS/2 decoder into single-cycle, one-hot move pulses for the player logic. It runs on the logic clock, upstream of the player stage.
- On press it emits one immediate pulse. If the key is still held after an initial delay, it emits repeat pulses at a fixed rate.
- It honours a ready handshake from the player so that no move is lost while the player is busy with map RAM access.

Parameters:
- DELAY_CYCLES, 12500000, cycles from the initial pulse to the first repeat (500 ms at 25 MHz); legal minimum 2.
- REPEAT_CYCLES, 5000000, cycles between subsequent repeats (200 ms at 25 MHz); legal minimum 2.
- CNT_W, 24, counter width; must hold max(DELAY_CYCLES, REPEAT_CYCLES).

Ports:
- clk  in  1  logic clock; single clock domain.
- rstn  in  1  asynchronous active-low reset.
- key_held  in  4  active-high held keys, ordered {right, up, down, left}; asynchronous to clk.
- ready  in  1  high when the player can accept a move this cycle.
- move  out  4  one-hot move pulse, same bit order; high for exactly one cycle per move.
- active  out  1  high while a direction is latched (FIRST or REPEAT state).
- dir  out  2  index of the latched direction (0=left, 1=down, 2=up, 3=right); 0 when idle.

Behaviour:
- Reset (asynchronous, rstn=0): move=0, active=0, dir=0, state=IDLE, counter=0, pending=0, synchroniser flops=0.
- Synchroniser: two flops per key_held bit. The FSM sees only the synchronised value ks.
- States:
  - IDLE: if any ks bit is set, latch the highest-index set bit into dir and go to FIRST with counter=0. Raise an emit event this same edge.
  - FIRST: counter increments each cycle. When counter==DELAY_CYCLES-1, raise an emit event, clear counter, go to REPEAT.
  - REPEAT: counter increments each cycle. When counter==REPEAT_CYCLES-1, raise an emit event and clear counter.
  - Any non-IDLE state: if ks[dir]==0, go to IDLE on that edge. No emit; pending cleared; counter cleared. Release takes priority over a coincident emit event.
- Other keys are ignored while a direction is latched. After release the FSM spends at least one cycle in IDLE, then picks the highest still-held key.
- Emit and handshake:
  - An emit event with ready=1 sets move = one-hot(dir) on that edge.
  - An emit event with ready=0 sets pending=1.
  - While pending=1 and ready=1, move = one-hot(dir) and pending clears.
  - A further emit event while pending=1 is coalesced: at most one pulse is outstanding and the counter keeps running.
- move is registered and returns to 0 on the next edge. It is never multi-hot and never high for two consecutive cycles.
- Latency: key_held rising before edge k gives move high in the cycle after edge k+2 (2 sync flops + 1 FSM edge).
- Timing with ready held high: initial pulse at edge t0; repeats at t0+DELAY_CYCLES, then every REPEAT_CYCLES after that.
- Counter width: compare at full CNT_W width. The counter never wraps, because it clears at terminal count or on state exit.
- Reset mid-operation: immediate return to the reset values above. No pulse is generated after rstn rises until a key is seen in IDLE.
- A glitch on key_held shorter than one clk period may be missed; no debouncing is done here (the PS/2 decoder delivers clean levels).

Test Plan (DELAY_CYCLES=8, REPEAT_CYCLES=4, ready=1 unless stated):
- Reset: rstn=0 with key_held=4'b1111 → move=0, active=0, dir=0 throughout. Release rstn → initial pulse move=4'b1000 exactly 3 edges after release.
- Tap: key_held=4'b0001 for 3 cycles → exactly one move=4'b0001 pulse. active falls 2 edges after the key drops; no further pulses.
- Hold down (0010) for 30 cycles → pulses at edges t0, t0+8, t0+12, t0+16, t0+20, t0+24, t0+28 (7 pulses, each one cycle wide).
- Priority/ignore: hold left, then add up 5 cycles later → only left pulses, dir=0. Release left → IDLE for 1 cycle, then an up pulse (4'b0100) with dir=2.
- Handshake: hold right with ready=0 for 20 cycles → no pulses, but pending is set. Raise ready → exactly one move=4'b1000 on the first ready edge (coalesced), then normal repeat cadence.
- Release-vs-emit race: release the key so the synchronised low arrives on the repeat terminal-count edge → no pulse, state=IDLE, pending=0.
